idu_rf_redirect_arb: RTL and testbench

Front-end redirect controller between the EXU branch/jump unit, the ROB commit port and the IDU/RF program counter. It buffers resolved branch/jump targets in program order, tagged by ROB id, and releases one as a PC redirect when the ROB commits the matching jump. It arbitrates that redirect against a ROB trap redirect and holds any redirect across front-end stalls. Its outputs drive the PC register's load-enable and load-value.

---
 rtl/idu_rf_redirect_arb.sv | 128 ++++++++++++
 tb/tb_idu_rf_redirect_arb.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/idu_rf_redirect_arb.sv
// idu_rf_redirect_arb
//   Front-end redirect controller. Resolved branch/jump targets from the EXU
//   are buffered in program order, tagged by ROB id. When the ROB commits the
//   jump at the head of the buffer, its target is released as a PC redirect.
//   A ROB trap takes priority over a jump commit. A redirect that meets a
//   front-end stall is held until the stall drops.
//
//   Handshake: a push is accepted on a rising clk edge where exu_bju_vld and
//   exu_bju_rdy are both high, unless a flush (trap or matching commit) happens
//   on that edge. exu_bju_rdy does not depend on exu_bju_vld.
//
// Ports
//   clk, rst_clk          clock, synchronous active-high reset
//   y_stall_ctrl          front-end stall; blocks redirect issue
//   exu_bju_vld/tag/addr  target push from the branch/jump unit
//   exu_bju_rdy           buffer not full
//   rob_jump_vld/tag      ROB commit of a taken branch/jump
//   rob_trap_vld/addr     ROB trap flush and trap vector
//   redir_vld/addr/src    registered PC load strobe, value and source
//   buf_cnt               number of occupied buffer entries
//   err_tag               one-cycle pulse on a commit that misses the head
//   dbg_state is not a port; the FSM state is the internal signal 'state'.
module idu_rf_redirect_arb #(
   parameter int          DEPTH    = 4,
   parameter int          TAG_W    = 4,
   parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
   input  logic                     clk,
   input  logic                     rst_clk,
   input  logic                     y_stall_ctrl,
   input  logic                     exu_bju_vld,
   input  logic [TAG_W-1:0]         exu_bju_tag,
   input  logic [63:0]              exu_bju_addr,
   output logic                     exu_bju_rdy,
   input  logic                     rob_jump_vld,
   input  logic [TAG_W-1:0]         rob_jump_tag,
   input  logic                     rob_trap_vld,
   input  logic [63:0]              rob_trap_addr,
   output logic                     redir_vld,
   output logic [63:0]              redir_addr,
   output logic [1:0]               redir_src,
   output logic [$clog2(DEPTH):0]   buf_cnt,
   output logic                     err_tag
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_FIRE = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [TAG_W-1:0] tag_mem  [DEPTH];
   logic [63:0]      addr_mem [DEPTH];
   logic [PW-1:0]    rd_ptr, wr_ptr;
   logic [63:0]      pend_addr, pend_addr_n;
   logic [1:0]       pend_src, pend_src_n;
   logic [CW-1:0]    cnt_n;

   logic buf_empty, head_hit, jump_cap, jump_err, capture, push_acc;

   assign buf_empty = (buf_cnt == '0);
   assign head_hit  = !buf_empty && (tag_mem[rd_ptr] == rob_jump_tag);
   // A commit arriving while a redirect is already held is not accepted.
   assign jump_cap  = rob_jump_vld && !rob_trap_vld && (state != ST_HOLD) && head_hit;
   assign jump_err  = rob_jump_vld && !rob_trap_vld && !jump_cap;
   assign capture   = rob_trap_vld || jump_cap;
   // Every capture flushes the buffer: all younger entries are wrong-path.
   assign push_acc  = exu_bju_vld && exu_bju_rdy && !capture;
   assign cnt_n     = capture ? '0 : buf_cnt + CW'(push_acc);

   always_comb begin
      state_n     = ST_IDLE;
      pend_addr_n = pend_addr;
      pend_src_n  = pend_src;
      if (capture) begin
         pend_addr_n = rob_trap_vld ? rob_trap_addr : addr_mem[rd_ptr];
         pend_src_n  = rob_trap_vld ? 2'b10 : 2'b01;
         state_n     = y_stall_ctrl ? ST_HOLD : ST_FIRE;
      end else begin
         case (state)
            ST_HOLD: state_n = y_stall_ctrl ? ST_HOLD : ST_FIRE;
            default: state_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_clk) begin
         state       <= ST_IDLE;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         buf_cnt     <= '0;
         exu_bju_rdy <= 1'b1;
         pend_addr   <= PC_RESET;
         pend_src    <= 2'b00;
         redir_vld   <= 1'b0;
         redir_src   <= 2'b00;
         redir_addr  <= PC_RESET;
         err_tag     <= 1'b0;
      end else begin
         state       <= state_n;
         pend_addr   <= pend_addr_n;
         pend_src    <= pend_src_n;
         redir_vld   <= (state_n == ST_FIRE);
         redir_src   <= (state_n == ST_FIRE) ? pend_src_n : 2'b00;
         if (state_n == ST_FIRE) redir_addr <= pend_addr_n;
         err_tag     <= jump_err;
         buf_cnt     <= cnt_n;
         exu_bju_rdy <= (cnt_n != CW'(DEPTH));
         if (push_acc) wr_ptr <= wr_ptr + PW'(1);
         // Flush by jumping the read pointer to the write pointer.
         if (capture) rd_ptr <= wr_ptr;
      end
   end

   // Entry storage needs no reset; occupancy is tracked by buf_cnt.
   always_ff @(posedge clk) begin
      if (!rst_clk && push_acc) begin
         tag_mem[wr_ptr]  <= exu_bju_tag;
         addr_mem[wr_ptr] <= exu_bju_addr;
      end
   end

endmodule

// File: tb/tb_idu_rf_redirect_arb.sv
module tb_idu_rf_redirect_arb;

   localparam int          DEPTH    = 4;
   localparam int          TAG_W    = 4;
   localparam logic [63:0] PC_RESET = 64'h0000_0000_8000_0000;

   logic             clk = 1'b0;
   logic             rst_clk;
   logic             y_stall_ctrl;
   logic             exu_bju_vld;
   logic [TAG_W-1:0] exu_bju_tag;
   logic [63:0]      exu_bju_addr;
   logic             exu_bju_rdy;
   logic             rob_jump_vld;
   logic [TAG_W-1:0] rob_jump_tag;
   logic             rob_trap_vld;
   logic [63:0]      rob_trap_addr;
   logic             redir_vld;
   logic [63:0]      redir_addr;
   logic [1:0]       redir_src;
   logic [2:0]       buf_cnt;
   logic             err_tag;

   int total = 0;
   int bad   = 0;
   logic [65:0] exp_q[$];   // {src, addr} of each expected redirect pulse

   idu_rf_redirect_arb #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PC_RESET(PC_RESET)) dut (
      .clk(clk), .rst_clk(rst_clk), .y_stall_ctrl(y_stall_ctrl),
      .exu_bju_vld(exu_bju_vld), .exu_bju_tag(exu_bju_tag), .exu_bju_addr(exu_bju_addr),
      .exu_bju_rdy(exu_bju_rdy), .rob_jump_vld(rob_jump_vld), .rob_jump_tag(rob_jump_tag),
      .rob_trap_vld(rob_trap_vld), .rob_trap_addr(rob_trap_addr), .redir_vld(redir_vld),
      .redir_addr(redir_addr), .redir_src(redir_src), .buf_cnt(buf_cnt), .err_tag(err_tag)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // scoreboard: every redirect pulse must match the oldest expectation
   always @(negedge clk) begin
      if (redir_vld === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_redir", {redir_src, redir_addr}, 66'h0);
         end else begin
            check("redir", {redir_src, redir_addr}, exp_q.pop_front());
         end
      end
   end

   // drivers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [TAG_W-1:0] t, input logic [63:0] a);
      exu_bju_vld = 1'b1; exu_bju_tag = t; exu_bju_addr = a;
      tick();
      exu_bju_vld = 1'b0;
   endtask

   task automatic commit(input logic [TAG_W-1:0] t);
      rob_jump_vld = 1'b1; rob_jump_tag = t;
      tick();
      rob_jump_vld = 1'b0;
   endtask

   initial begin
      rst_clk = 1'b1; y_stall_ctrl = 1'b0;
      exu_bju_vld = 1'b0; exu_bju_tag = '0; exu_bju_addr = '0;
      rob_jump_vld = 1'b0; rob_jump_tag = '0;
      rob_trap_vld = 1'b0; rob_trap_addr = '0;
      tick(); tick();
      rst_clk = 1'b0;
      check("rst_vld",  66'(redir_vld), 66'd0);
      check("rst_addr", 66'(redir_addr), 66'(PC_RESET));
      check("rst_src",  66'(redir_src), 66'd0);
      check("rst_cnt",  66'(buf_cnt), 66'd0);
      check("rst_rdy",  66'(exu_bju_rdy), 66'd1);
      check("rst_err",  66'(err_tag), 66'd0);

      // 1: tag match
      push(4'd3, 64'h8000_0100);
      check("t1_cnt_push", 66'(buf_cnt), 66'd1);
      exp_q.push_back({2'b01, 64'h8000_0100});
      commit(4'd3);
      check("t1_vld", 66'(redir_vld), 66'd1);
      check("t1_cnt", 66'(buf_cnt), 66'd0);
      tick();
      check("t1_vld_off", 66'(redir_vld), 66'd0);
      check("t1_addr_hold", 66'(redir_addr), 66'h8000_0100);

      // 2: stalled redirect
      push(4'd5, 64'h8000_0500);
      y_stall_ctrl = 1'b1;
      exp_q.push_back({2'b01, 64'h8000_0500});
      commit(4'd5);
      for (int i = 0; i < 3; i++) begin
         check("t2_stall_vld", 66'(redir_vld), 66'd0);
         tick();
      end
      check("t2_stall_vld", 66'(redir_vld), 66'd0);
      y_stall_ctrl = 1'b0;
      tick();
      check("t2_fire", 66'(redir_vld), 66'd1);
      tick();
      check("t2_once", 66'(redir_vld), 66'd0);

      // 3: trap replaces a held jump, with a simultaneous commit ignored
      push(4'd9, 64'h8000_0900);
      y_stall_ctrl = 1'b1;
      commit(4'd9);
      tick();
      exp_q.push_back({2'b10, 64'h8000_0004});
      rob_trap_vld = 1'b1; rob_trap_addr = 64'h8000_0004;
      rob_jump_vld = 1'b1; rob_jump_tag = 4'd9;
      tick();
      rob_trap_vld = 1'b0; rob_jump_vld = 1'b0;
      check("t3_no_err", 66'(err_tag), 66'd0);
      check("t3_held", 66'(redir_vld), 66'd0);
      y_stall_ctrl = 1'b0;
      tick();
      check("t3_src", 66'(redir_src), 66'd2);
      tick();

      // 4: full buffer, dropped push, refill across the wrap
      for (int i = 0; i < 4; i++) push(4'(i), 64'h8000_1000 + 64'(i * 16));
      check("t4_cnt_full", 66'(buf_cnt), 66'd4);
      check("t4_rdy_full", 66'(exu_bju_rdy), 66'd0);
      push(4'd4, 64'hDEAD_0000);
      check("t4_cnt_drop", 66'(buf_cnt), 66'd4);
      exp_q.push_back({2'b01, 64'h8000_1000});
      commit(4'd0);
      check("t4_cnt_flush0", 66'(buf_cnt), 66'd0);
      check("t4_rdy_flush", 66'(exu_bju_rdy), 66'd1);
      tick();
      push(4'd1, 64'h8000_2010);
      exp_q.push_back({2'b01, 64'h8000_2010});
      commit(4'd1);
      check("t4_cnt_flush1", 66'(buf_cnt), 66'd0);
      tick();

      // 5: empty commit and mismatched commit
      commit(4'd7);
      check("t5_err_empty", 66'(err_tag), 66'd1);
      check("t5_cnt_empty", 66'(buf_cnt), 66'd0);
      tick();
      check("t5_err_off", 66'(err_tag), 66'd0);
      push(4'd2, 64'h8000_0200);
      commit(4'd6);
      check("t5_err_miss", 66'(err_tag), 66'd1);
      check("t5_cnt_miss", 66'(buf_cnt), 66'd1);

      // 6: push collides with trap flush
      exp_q.push_back({2'b10, 64'h8000_00C0});
      rob_trap_vld = 1'b1; rob_trap_addr = 64'h8000_00C0;
      push(4'd8, 64'h8000_0800);
      rob_trap_vld = 1'b0;
      check("t6_cnt_collide", 66'(buf_cnt), 66'd0);
      tick();

      // 6: reset in the FIRE cycle
      push(4'd4, 64'h8000_0400);
      exp_q.push_back({2'b01, 64'h8000_0400});
      commit(4'd4);
      check("t6_fire", 66'(redir_vld), 66'd1);
      rst_clk = 1'b1;
      tick();
      rst_clk = 1'b0;
      check("t6_rst_vld", 66'(redir_vld), 66'd0);
      check("t6_rst_addr", 66'(redir_addr), 66'(PC_RESET));

      // reset during HOLD drops the pending redirect
      push(4'd1, 64'h8000_0110);
      y_stall_ctrl = 1'b1;
      commit(4'd1);
      rst_clk = 1'b1;
      tick();
      rst_clk = 1'b0; y_stall_ctrl = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("t6_hold_drop", 66'(redir_vld), 66'd0);
      check("exp_q_empty", 66'(exp_q.size()), 66'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
